// File: rtl/mac_array_drain.sv
// mac_array_drain: captures per-lane MAC results, buffers complete sets and streams them one word per beat.
module mac_array_drain #(
  parameter int ACC_W  = 16,
  parameter int N_MACS = 4,
  parameter int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] acc_in_0,
  input  logic signed [ACC_W-1:0] acc_in_1,
  input  logic signed [ACC_W-1:0] acc_in_2,
  input  logic signed [ACC_W-1:0] acc_in_3,
  input  logic [N_MACS-1:0]       valid_in,
  output logic [N_MACS-1:0]       clear_out,
  output logic [ACC_W-1:0]        out_data,
  output logic [1:0]              out_lane,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    busy
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc [N_MACS];
  logic [N_MACS-1:0][ACC_W-1:0] hold;
  logic [N_MACS-1:0][ACC_W-1:0] mem [DEPTH];
  logic [N_MACS-1:0] pending, pending_nxt, cap;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic [1:0] lane;
  logic beat, pop, push;
  assign acc[0] = acc_in_0;
  assign acc[1] = acc_in_1;
  assign acc[2] = acc_in_2;
  assign acc[3] = acc_in_3;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // A pop frees a slot on the same edge, so a full buffer still accepts a push then.
  always_comb begin
    cap         = valid_in & ~pending;
    beat        = out_valid & out_ready;
    pop         = beat & (lane == 2'd3);
    push        = &pending && (count < CW'(DEPTH) || pop);
    pending_nxt = (pending & {N_MACS{~push}}) | cap;
    count_nxt   = count + CW'(push) - CW'(pop);
    state_nxt   = count_nxt != '0 ? SEND : IDLE;
  end
  assign out_valid = state == SEND;
  assign out_data  = out_valid ? mem[rptr][lane] : '0;
  assign out_lane  = lane;
  assign out_last  = out_valid && lane == 2'd3;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      clear_out <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      lane      <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      clear_out <= cap;
      overflow  <= overflow | (|(valid_in & pending));
      busy      <= (|pending_nxt) || count_nxt != '0;
      count     <= count_nxt;
      if (beat) lane <= lane + 2'd1;
      if (pop) rptr <= inc(rptr);
      if (push) wptr <= inc(wptr);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wptr] <= hold;
    for (int i = 0; i < N_MACS; i++)
      if (cap[i]) hold[i] <= acc[i];
  end
endmodule

// File: tb/tb_mac_array_drain.sv
// tb_mac_array_drain: directed and random stimulus checked against a queue-based model of the drain.
module tb_mac_array_drain;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, rdy = 0;
  logic [3:0] vin = 0;
  logic signed [15:0] acc [4] = '{0, 0, 0, 0};
  logic [3:0] clear_out;
  logic [15:0] out_data;
  logic [1:0] out_lane;
  logic out_last, out_valid, overflow, busy;
  int checks = 0, errors = 0, clr2_cnt = 0;
  logic [17:0] beats[$];
  logic [15:0] m_hold [4];
  logic [3:0] m_pend = 0, m_clr = 0;
  logic m_ovf = 0, m_valid = 0;
  logic [1:0] m_lane = 0;
  logic [63:0] m_q[$];

  mac_array_drain #(.ACC_W(16), .N_MACS(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .acc_in_0(acc[0]), .acc_in_1(acc[1]), .acc_in_2(acc[2]),
    .acc_in_3(acc[3]), .valid_in(vin), .clear_out(clear_out), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .out_valid(out_valid), .out_ready(rdy),
    .overflow(overflow), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: hold registers feeding a bounded queue of complete sets.
  task automatic m_edge();
    logic b, pop, push;
    logic [3:0] cap;
    logic [63:0] s;
    if (rst) begin
      m_pend = 0; m_clr = 0; m_ovf = 0; m_valid = 0; m_lane = 0;
      m_q.delete();
      return;
    end
    b = m_valid && rdy;
    pop = b && m_lane == 2'd3;
    push = &m_pend && (m_q.size() < DEPTH || pop);
    s = {m_hold[3], m_hold[2], m_hold[1], m_hold[0]};
    cap = vin & ~m_pend;
    if (|(vin & m_pend)) m_ovf = 1;
    for (int i = 0; i < 4; i++) if (cap[i]) m_hold[i] = acc[i];
    m_clr = cap;
    m_pend = (push ? 4'b0 : m_pend) | cap;
    if (b) m_lane = m_lane + 2'd1;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(s);
    m_valid = m_q.size() > 0;
  endtask

  task automatic compare_all();
    logic [63:0] h;
    int l;
    h = m_valid ? m_q[0] : 64'd0;
    l = int'(m_lane);
    chk("valid", 64'(out_valid), 64'(m_valid));
    chk("data", 64'(out_data), 64'(h[16*l +: 16]));
    chk("lane", 64'(out_lane), 64'(m_lane));
    chk("last", 64'(out_last), 64'(m_valid && m_lane == 2'd3));
    chk("clear", 64'(clear_out), 64'(m_clr));
    chk("ovf", 64'(overflow), 64'(m_ovf));
    chk("busy", 64'(busy), 64'((|m_pend) || m_q.size() > 0));
  endtask

  task automatic tick();
    if (out_valid && rdy) beats.push_back({out_lane, out_data});
    if (clear_out[2]) clr2_cnt++;
    m_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_acc(input int a0, input int a1, input int a2, input int a3);
    acc[0] = 16'(a0); acc[1] = 16'(a1); acc[2] = 16'(a2); acc[3] = 16'(a3);
  endtask

  task automatic do_reset();
    rst = 1; vin = 0;
    tick();
    rst = 0;
  endtask

  initial begin
    logic [15:0] sv [4];
    // reset state
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);

    // single set
    rdy = 1; beats.delete();
    set_acc(5, -3, 32767, -32768); vin = 4'b1111;
    tick();
    chk("single_clear", 64'(clear_out), 64'hf);
    vin = 0;
    tick();
    chk("single_rise", 64'(out_valid), 1);
    chk("single_d0", 64'(out_data), 64'h5);
    repeat (4) tick();
    sv = '{16'h0005, 16'hfffd, 16'h7fff, 16'h8000};
    chk("single_n", 64'(beats.size()), 4);
    for (int i = 0; i < beats.size() && i < 4; i++) chk("single_beat", 64'(beats[i]), 64'({2'(i), sv[i]}));
    chk("single_idle", 64'(busy), 0);

    // staggered lanes
    beats.delete(); set_acc(1, 2, 3, 4);
    for (int c = 0; c <= 12; c++) begin
      vin = c == 0 ? 4'b0001 : c == 3 ? 4'b0010 : c == 4 ? 4'b0100 : c == 9 ? 4'b1000 : 4'b0000;
      tick();
      if (c == 9) chk("stag_pre", 64'(out_valid), 0);
      if (c == 10) chk("stag_rise", 64'(out_valid), 1);
    end
    repeat (4) tick();
    chk("stag_n", 64'(beats.size()), 4);
    for (int i = 0; i < beats.size() && i < 4; i++) chk("stag_beat", 64'(beats[i]), 64'({2'(i), 16'(i + 1)}));

    // backpressure
    beats.delete(); rdy = 0;
    set_acc(40, 41, 42, 43); vin = 4'b1111;
    tick();
    vin = 0;
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    chk("bp_valid", 64'(out_valid), 1);
    repeat (5) begin
      tick();
      chk("bp_hold", 64'({out_lane, out_data}), 64'({2'd0, 16'd40}));
    end
    rdy = 1;
    repeat (5) tick();
    chk("bp_n", 64'(beats.size()), 4);
    for (int i = 0; i < beats.size() && i < 4; i++) chk("bp_beat", 64'(beats[i]), 64'({2'(i), 16'(40 + i)}));

    // buffer full, then overflow on a stuck pending lane
    beats.delete(); rdy = 0;
    for (int c = 0; c <= 12; c++) begin
      vin = 0;
      if (c == 0 || c == 4 || c == 8) begin
        set_acc(100*(c/4+1), 100*(c/4+1)+1, 100*(c/4+1)+2, 100*(c/4+1)+3);
        vin = 4'b1111;
      end
      if (c == 12) begin acc[0] = 16'sd999; vin = 4'b0001; end
      tick();
    end
    vin = 0;
    chk("full_ovf", 64'(overflow), 1);
    chk("full_noclr", 64'(clear_out[0]), 0);
    rdy = 1;
    repeat (16) tick();
    chk("full_n", 64'(beats.size()), 12);
    for (int i = 0; i < beats.size() && i < 12; i++)
      chk("full_beat", 64'(beats[i]), 64'({2'(i % 4), 16'(100*(i/4+1) + i%4)}));
    do_reset();
    chk("full_rst_ovf", 64'(overflow), 0);

    // double strobe on lane 2
    beats.delete(); clr2_cnt = 0; rdy = 1;
    acc[2] = 16'sd7; vin = 4'b0100; tick();
    vin = 0; tick();
    acc[2] = 16'sd9; vin = 4'b0100; tick();
    vin = 0; tick();
    set_acc(10, 11, 9, 13); vin = 4'b1011; tick();
    vin = 0;
    repeat (8) tick();
    chk("dbl_ovf", 64'(overflow), 1);
    chk("dbl_clr2", 64'(clr2_cnt), 1);
    chk("dbl_n", 64'(beats.size()), 4);
    if (beats.size() == 4) chk("dbl_lane2", 64'(beats[2]), 64'({2'd2, 16'd7}));
    do_reset();

    // reset mid-drain
    set_acc(21, 22, 23, 24); vin = 4'b1111; tick();
    vin = 0;
    for (int k = 0; k < 20 && !(out_valid && out_lane == 2'd1); k++) tick();
    chk("mid_lane1", 64'({out_valid, out_lane}), 64'({1'b1, 2'd1}));
    tick();
    rst = 1; tick(); rst = 0;
    chk("mid_rst", 64'({clear_out, out_data, out_lane, out_last, out_valid, overflow, busy}), 0);
    beats.delete();
    repeat (5) tick();
    chk("mid_stale", 64'(beats.size()), 0);
    set_acc(31, 32, 33, 34); vin = 4'b1111; tick();
    vin = 0;
    repeat (8) tick();
    chk("mid_n", 64'(beats.size()), 4);
    for (int i = 0; i < beats.size() && i < 4; i++) chk("mid_beat", 64'(beats[i]), 64'({2'(i), 16'(31 + i)}));

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        vin[i] = $urandom_range(0, 3) == 0;
        acc[i] = 16'($urandom);
      end
      rdy = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 199) == 0;
      tick();
    end
    rst = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
